// File: rtl/huffman_frame_ctrl.sv
// Frame sequencer for the Huffman encoder. It loads FRAME_LEN symbols into the encoder and
// waits for the code build. It then drains the (symbol, length, code) entries into a code-table RAM.
module huffman_frame_ctrl #(
  parameter int SYM_W       = 3,
  parameter int NUM_SYMBOLS = 8,
  parameter int FRAME_LEN   = 20,
  parameter int TIMEOUT     = 255
) (
  input  logic                               clock,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               src_valid,
  input  logic [SYM_W-1:0]                   src_data,
  output logic                               src_ready,
  output logic [SYM_W-1:0]                   enc_data_in,
  output logic                               enc_data_enable,
  input  logic                               enc_out_state,
  input  logic [NUM_SYMBOLS-1:0]             enc_symbol,
  input  logic [3:0]                         enc_length,
  input  logic [7:0]                         enc_code,
  output logic                               tbl_we,
  output logic [SYM_W-1:0]                   tbl_addr,
  output logic [3:0]                         tbl_length,
  output logic [7:0]                         tbl_code,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [3:0]                         entry_count,
  output logic [2:0]                         dbg_state,
  output logic [$clog2(FRAME_LEN + 1)-1:0]   dbg_sym_cnt
);

  // Source handshake: a symbol transfers on a rising edge where src_valid && src_ready.
  // src_ready is decoded from the state alone and never depends on src_valid.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_BUILD  = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int PROC_W = $clog2(NUM_SYMBOLS + 1);

  localparam logic [CNT_W-1:0]       LAST_SYM   = CNT_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0]       LAST_TICK  = TMR_W'(TIMEOUT - 1);
  localparam logic [PROC_W-1:0]      LAST_ENTRY = PROC_W'(NUM_SYMBOLS - 1);
  localparam logic [3:0]             MAX_COUNT  = 4'(NUM_SYMBOLS);
  localparam logic [NUM_SYMBOLS-1:0] SYM_ONE    = NUM_SYMBOLS'(1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    sym_cnt;
  logic [TMR_W-1:0]    timer;
  logic [PROC_W-1:0]   proc_cnt;
  logic [SYM_W-1:0]    entry_idx;

  logic start_frame;
  logic accept;
  logic last_accept;
  logic entry_valid;
  logic entry_absent;
  logic entry_onehot;
  logic entry_bad;
  logic entry_write;
  logic last_entry;
  logic timeout_hit;

  assign start_frame  = (state == S_IDLE) && start;
  assign accept       = (state == S_LOAD) && src_valid;
  assign last_accept  = accept && (sym_cnt == LAST_SYM);
  assign entry_valid  = ((state == S_BUILD) || (state == S_DRAIN)) && enc_out_state;
  assign entry_absent = (enc_length == 4'd0);
  assign entry_onehot = (enc_symbol != '0) && ((enc_symbol & (enc_symbol - SYM_ONE)) == '0);
  // An absent symbol is skipped before the one-hot/length checks, so it never flags an error.
  assign entry_bad    = !entry_absent && (!entry_onehot || (enc_length > 4'd8));
  assign entry_write  = entry_valid && !entry_absent && !entry_bad;
  assign last_entry   = entry_valid && (proc_cnt == LAST_ENTRY);
  assign timeout_hit  = (state == S_BUILD) && !enc_out_state && (timer == LAST_TICK);

  always_comb begin
    entry_idx = '0;
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      if (enc_symbol[i]) entry_idx = SYM_W'(i);
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (last_accept) state_nxt = S_BUILD;
      S_BUILD: begin
        if (enc_out_state)    state_nxt = last_entry ? S_FINISH : S_DRAIN;
        else if (timeout_hit) state_nxt = S_FINISH;
      end
      S_DRAIN:  if (!enc_out_state || last_entry) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    src_ready = (state == S_LOAD);
    busy      = (state != S_IDLE);
    done      = (state == S_FINISH);
    dbg_state = state;
  end

  assign dbg_sym_cnt = sym_cnt;

  // Datapath: symbol replay, build timer, table write pipeline and status.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sym_cnt         <= '0;
      timer           <= '0;
      proc_cnt        <= '0;
      enc_data_in     <= '0;
      enc_data_enable <= 1'b0;
      tbl_we          <= 1'b0;
      tbl_addr        <= '0;
      tbl_length      <= '0;
      tbl_code        <= '0;
      entry_count     <= '0;
      error           <= 1'b0;
    end else begin
      if (start_frame)  sym_cnt <= '0;
      else if (accept)  sym_cnt <= sym_cnt + 1'b1;

      if (state == S_BUILD) timer <= timer + 1'b1;
      else                  timer <= '0;

      if (start_frame)       proc_cnt <= '0;
      else if (entry_valid)  proc_cnt <= proc_cnt + 1'b1;

      if (accept) begin
        enc_data_enable <= 1'b1;
        enc_data_in     <= src_data;
      end else if (state == S_BUILD) begin
        enc_data_enable <= 1'b0;
        enc_data_in     <= '0;
      end else begin
        enc_data_enable <= 1'b0;
      end

      tbl_we <= entry_write;
      if (entry_write) begin
        tbl_addr   <= entry_idx;
        tbl_length <= enc_length;
        tbl_code   <= enc_code;
      end

      if (start_frame)
        entry_count <= '0;
      else if (entry_write && (entry_count < MAX_COUNT))
        entry_count <= entry_count + 4'd1;

      if (start_frame)
        error <= 1'b0;
      else if ((entry_valid && entry_bad) || timeout_hit)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// Directed bench for huffman_frame_ctrl: frame load, table drain, bad entries, build timeout
// and mid-frame reset, with expected-value queues for encoder and table traffic.
module tb_huffman_frame_ctrl;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_BUILD  = 3'd2;
  localparam logic [2:0] ST_FINISH = 3'd4;

  logic       clock;
  logic       rst_n;
  logic       start;
  logic       src_valid;
  logic [2:0] src_data;
  logic       src_ready;
  logic [2:0] enc_data_in;
  logic       enc_data_enable;
  logic       enc_out_state;
  logic [7:0] enc_symbol;
  logic [3:0] enc_length;
  logic [7:0] enc_code;
  logic       tbl_we;
  logic [2:0] tbl_addr;
  logic [3:0] tbl_length;
  logic [7:0] tbl_code;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] entry_count;
  logic [2:0] dbg_state;
  logic [4:0] dbg_sym_cnt;

  huffman_frame_ctrl #(
    .SYM_W(3), .NUM_SYMBOLS(8), .FRAME_LEN(20), .TIMEOUT(255)
  ) dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .enc_data_in(enc_data_in), .enc_data_enable(enc_data_enable),
    .enc_out_state(enc_out_state), .enc_symbol(enc_symbol),
    .enc_length(enc_length), .enc_code(enc_code),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_length(tbl_length), .tbl_code(tbl_code),
    .busy(busy), .done(done), .error(error), .entry_count(entry_count),
    .dbg_state(dbg_state), .dbg_sym_cnt(dbg_sym_cnt)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int checks = 0;
  int errors = 0;
  int enc_pulses = 0;
  int done_cnt = 0;
  logic [31:0] enc_exp_q[$];
  logic [31:0] tbl_exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every encoder and table strobe must match the queue head, including its cycle.
  always @(negedge clock) begin
    if (enc_data_enable) begin
      enc_pulses++;
      if (enc_exp_q.size() == 0) check("enc_extra", 32'd1, 32'd0);
      else check("enc_sym", {cyc[15:0], 13'b0, enc_data_in}, enc_exp_q.pop_front());
    end
    if (tbl_we) begin
      if (tbl_exp_q.size() == 0) check("tbl_extra", 32'd1, 32'd0);
      else check("tbl_entry", {cyc[15:0], 1'b0, tbl_addr, tbl_length, tbl_code},
                 tbl_exp_q.pop_front());
    end
    if (done) done_cnt++;
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_state", dbg_state, ST_LOAD);
    check("start_busy", busy, 1);
    check("start_error_clr", error, 0);
    check("start_count_clr", entry_count, 0);
    check("start_symcnt", dbg_sym_cnt, 0);
  endtask

  task automatic load_syms(input int count, input bit gaps, input bit reverse);
    int  sent = 0;
    bit  idle_slot = 1'b0;
    logic [15:0] c;
    while (sent < count) begin
      if (gaps && idle_slot) begin
        src_valid = 1'b0;
      end else begin
        src_valid = 1'b1;
        src_data  = reverse ? 3'(7 - (sent % 8)) : 3'(sent % 8);
        check("src_ready", src_ready, 1);
        c = 16'(cyc + 1);
        enc_exp_q.push_back({c, 13'b0, src_data});
        sent++;
      end
      idle_slot = !idle_slot;
      step();
    end
    src_valid = 1'b0;
  endtask

  task automatic drive_table(input logic [7:0][7:0] syms, input logic [7:0][3:0] lens,
                             input logic [7:0] we_mask);
    logic [15:0] c;
    repeat (3) step();
    check("build_enable", enc_data_enable, 0);
    check("build_data", enc_data_in, 0);
    for (int i = 0; i < 8; i++) begin
      enc_out_state = 1'b1;
      enc_symbol    = syms[i];
      enc_length    = lens[i];
      enc_code      = 8'hA0 + 8'(i);
      if (we_mask[i]) begin
        c = 16'(cyc + 1);
        tbl_exp_q.push_back({c, 1'b0, 3'(i), lens[i], 8'hA0 + 8'(i)});
      end
      step();
    end
    enc_out_state = 1'b0;
    enc_symbol    = '0;
    enc_length    = '0;
    enc_code      = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dbg_state != ST_IDLE && n < 50) begin
      step();
      n++;
    end
    check(tag, {31'b0, dbg_state == ST_IDLE}, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, dbg_state, ST_IDLE);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, src_ready, 0);
    check({tag, "_enc_en"}, enc_data_enable, 0);
    check({tag, "_enc_in"}, enc_data_in, 0);
    check({tag, "_tbl"}, {tbl_we, tbl_addr, tbl_length, tbl_code}, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_count"}, entry_count, 0);
  endtask

  logic [7:0][7:0] syms_ok;
  logic [7:0][7:0] syms_bad;
  logic [7:0][3:0] lens_drain;
  logic [7:0][3:0] lens_bad;
  int pulses0;
  int done0;
  int build_cycles;

  initial begin
    syms_ok    = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    syms_bad   = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h06, 8'h02, 8'h01};
    lens_drain = {4'd4, 4'd0, 4'd4, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2};
    lens_bad   = {4'd9, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    // Reset held with start and src_valid asserted
    rst_n = 1'b0; start = 1'b1; src_valid = 1'b1; src_data = 3'd5;
    enc_out_state = 1'b0; enc_symbol = '0; enc_length = '0; enc_code = '0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1; start = 1'b0; src_valid = 1'b0;
    step();
    check_all_zero("post_reset");

    // Nominal frame, continuous source, then table drain with one absent symbol
    pulses0 = enc_pulses; done0 = done_cnt;
    start_frame();
    load_syms(20, 1'b0, 1'b0);
    check("nom_ready_low", src_ready, 0);
    check("nom_state_build", dbg_state, ST_BUILD);
    check("nom_symcnt", dbg_sym_cnt, 20);
    drive_table(syms_ok, lens_drain, 8'b1011_1111);
    wait_idle("nom_idle");
    check("nom_pulses", enc_pulses - pulses0, 20);
    check("nom_done", done_cnt - done0, 1);
    check("nom_count", entry_count, 7);
    check("nom_error", error, 0);
    check("nom_tbl_q", tbl_exp_q.size(), 0);

    // Back-pressured source, bad one-hot entry and an over-long code
    pulses0 = enc_pulses; done0 = done_cnt;
    start_frame();
    load_syms(20, 1'b1, 1'b1);
    check("bp_ready_low", src_ready, 0);
    check("bp_symcnt", dbg_sym_cnt, 20);
    drive_table(syms_bad, lens_bad, 8'b0111_1011);
    wait_idle("bp_idle");
    check("bp_pulses", enc_pulses - pulses0, 20);
    check("bp_done", done_cnt - done0, 1);
    check("bad_count", entry_count, 6);
    check("bad_error", error, 1);
    check("bad_tbl_q", tbl_exp_q.size(), 0);

    // Build timeout; the start also shows the sticky error being cleared
    done0 = done_cnt;
    start_frame();
    load_syms(20, 1'b0, 1'b0);
    build_cycles = 0;
    while (dbg_state == ST_BUILD && build_cycles < 400) begin
      build_cycles++;
      step();
    end
    check("to_cycles", build_cycles, 255);
    check("to_state_finish", dbg_state, ST_FINISH);
    check("to_done", done, 1);
    check("to_error", error, 1);
    step();
    check("to_state_idle", dbg_state, ST_IDLE);
    check("to_busy", busy, 0);
    check("to_done_once", done_cnt - done0, 1);
    check("to_error_sticky", error, 1);

    // Mid-frame reset after 10 symbols
    done0 = done_cnt;
    start_frame();
    load_syms(10, 1'b0, 1'b0);
    check("mid_state_load", dbg_state, ST_LOAD);
    rst_n = 1'b0;
    step();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    step();
    check("mid_no_done", done_cnt - done0, 0);
    check("mid_enc_q", enc_exp_q.size(), 0);

    // Fresh frame after the abort must count a full 20 symbols again
    pulses0 = enc_pulses; done0 = done_cnt;
    start_frame();
    load_syms(20, 1'b0, 1'b1);
    check("re_ready_low", src_ready, 0);
    check("re_symcnt", dbg_sym_cnt, 20);
    drive_table(syms_ok, lens_drain, 8'b1011_1111);
    wait_idle("re_idle");
    check("re_pulses", enc_pulses - pulses0, 20);
    check("re_done", done_cnt - done0, 1);
    check("re_count", entry_count, 7);
    check("re_error", error, 0);

    step();
    check("final_enc_q", enc_exp_q.size(), 0);
    check("final_tbl_q", tbl_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_frame_ctrl.md
Name: huffman_frame_ctrl

Overview:
Frame sequencer for the Huffman_encoder datapath. It accepts a frame of FRAME_LEN symbols from an upstream valid/ready source and replays them into the encoder's data_in/data_enable interface. It then waits for the encoder to finish building its code, and drains the emitted (symbol, length, code) entries into a downstream code-table RAM. It also reports completion and error status to the system controller.

Parameters:
SYM_W, 3, symbol width; matches the encoder data_in width.
NUM_SYMBOLS, 8, alphabet size, equal to 2**SYM_W; width of the one-hot enc_symbol.
FRAME_LEN, 20, symbols per frame; matches the encoder frame parameter.
TIMEOUT, 255, maximum number of cycles spent in BUILD waiting for the encoder before an error is raised.

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request to begin a frame; sampled only in IDLE
src_valid  in  1  upstream symbol valid
src_data  in  SYM_W  upstream symbol
src_ready  out  1  upstream symbol accepted when src_valid&&src_ready
enc_data_in  out  SYM_W  to encoder data_in
enc_data_enable  out  1  to encoder data_enable
enc_out_state  in  1  encoder data_out_state; high while table entries stream out
enc_symbol  in  NUM_SYMBOLS  encoder data_out_symbol, one-hot
enc_length  in  4  encoder data_out_length
enc_code  in  8  encoder data_out_code
tbl_we  out  1  code-table write strobe
tbl_addr  out  SYM_W  binary symbol index
tbl_length  out  4  code length written
tbl_code  out  8  code word written
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of frame, on both success and error
error  out  1  sticky; cleared on the next accepted start
entry_count  out  4  number of table entries written in the current frame

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE.
  - All outputs are 0, including enc_data_in, tbl_* and entry_count.
  - Internal counters are cleared.
  - Reset asserted mid-frame aborts the frame immediately. No done pulse is produced and no further tbl_we is issued.
- State machine (states IDLE, LOAD, BUILD, DRAIN, FINISH):
  - IDLE -> LOAD when start=1. On that edge, error, entry_count and sym_cnt are cleared. start in any other state is ignored.
  - LOAD:
    - src_ready = 1, decoded combinationally from the state only.
    - Each handshake increments sym_cnt. On the next cycle, enc_data_enable=1 and enc_data_in=src_data (registered, latency 1).
    - Cycles without a handshake drive enc_data_enable=0; enc_data_in holds its last value.
    - The handshake that makes sym_cnt==FRAME_LEN moves to BUILD, so src_ready is low from the following cycle.
  - BUILD:
    - enc_data_enable=0 and enc_data_in=0; the timer counts up each cycle.
    - enc_out_state=1 moves to DRAIN, and that same cycle's entry is processed.
    - If the timer reaches TIMEOUT first: error=1 and the state moves to FINISH.
  - DRAIN: each cycle with enc_out_state=1 processes one entry.
    - enc_length==0: the symbol is absent; no write.
    - enc_symbol is not one-hot, or enc_length>8: error=1; no write.
    - Otherwise, on the next cycle: tbl_we=1, tbl_addr=index of the set bit, tbl_length=enc_length, tbl_code=enc_code. entry_count increments.
    - enc_out_state=0, or NUM_SYMBOLS entries processed, moves to FINISH. Any entries beyond that are ignored.
  - FINISH: done=1 for one cycle, then IDLE. The last tbl_we and done may coincide.
- tbl_* outputs other than tbl_we hold their last values when tbl_we=0.
- entry_count saturates at NUM_SYMBOLS and holds its value in IDLE until the next start.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 and src_valid=1. All outputs must be 0 and the state must remain IDLE.
- Nominal frame: pulse start, then stream 20 symbols with continuous src_valid (sequence 0..7 repeated). Required response:
  - enc_data_enable high for exactly 20 consecutive cycles, lagging src by 1 cycle, with enc_data_in matching the sequence.
  - src_ready low after the 20th accept.
- Source back-pressure: src_valid toggles 1/0. enc_data_enable must pulse only for accepted symbols, 20 pulses in total; sym_cnt must not overcount.
- Table drain: encoder model raises enc_out_state for 8 cycles with enc_symbol=8'b00000001..8'b10000000 and lengths {2,2,3,3,3,4,0,4}. Required response:
  - 7 tbl_we pulses with tbl_addr 0..5 and 7; no write for symbol 6.
  - entry_count=7, done pulses once, error=0.
- Bad entry: enc_symbol=8'b00000110 on one entry. error=1 and no write occurs for that entry; the remaining entries are still written. error clears on the next start.
- Timeout: encoder model never raises enc_out_state. After 255 BUILD cycles, error=1, done pulses, state returns to IDLE, busy=0.
- Mid-frame reset: assert rst_n=0 during LOAD after 10 symbols. Required response:
  - Next cycle: all outputs 0, no done pulse.
  - A new start begins with sym_cnt=0.
